// File: rtl/ah_arbitrated_multiplexor_8_8_pkg.sv
// Shared constants and helpers for the round-robin arbitrated multiplexor.
package ah_mux_pkg;

   localparam int AH_DATA_WIDTH   = 8;
   localparam int AH_NUM_CHANNELS = 8;
   localparam int AH_PTR_W        = $clog2(AH_NUM_CHANNELS);
   localparam int AH_ONEHOT_MAX   = 32;

   // Wide enough for any supported channel count; callers keep the low bits.
   function automatic logic [AH_ONEHOT_MAX-1:0] idx_to_onehot(input logic [31:0] idx);
      return {{(AH_ONEHOT_MAX-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/ah_arbitrated_multiplexor_8_8_if.sv
// Many-to-one stream bundle: per-channel producer side plus the shared output side.
interface ah_mux_if
   import ah_mux_pkg::*;
#(
   parameter int DATA_WIDTH   = AH_DATA_WIDTH,
   parameter int NUM_CHANNELS = AH_NUM_CHANNELS
) ();

   logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data;
   logic [NUM_CHANNELS-1:0]            in_valid;
   logic [NUM_CHANNELS-1:0]            in_ready;
   logic [DATA_WIDTH-1:0]              out_data;
   logic                               out_valid;
   logic                               out_ready;
   logic [NUM_CHANNELS-1:0]            out_select;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_select
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_select
   );

endinterface

// File: rtl/ah_arbitrated_multiplexor_8_8_arbiter.sv
// Combinational round-robin arbiter: first requester after last_grant, wrapping.
module ah_round_robin_arbiter
   import ah_mux_pkg::*;
#(
   parameter int NUM_CHANNELS = AH_NUM_CHANNELS
) (
   input  logic [NUM_CHANNELS-1:0]         request,
   input  logic [$clog2(NUM_CHANNELS)-1:0] last_grant,
   input  logic                            enable,
   output logic [NUM_CHANNELS-1:0]         grant_oh,
   output logic [$clog2(NUM_CHANNELS)-1:0] grant_idx,
   output logic                            grant_valid
);

   localparam int PTR_W = $clog2(NUM_CHANNELS);

   logic                     found;
   logic [PTR_W-1:0]         idx;
   logic [PTR_W-1:0]         cand;
   logic [AH_ONEHOT_MAX-1:0] oh_wide;
   logic                     unused_oh_hi;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = 1; k <= NUM_CHANNELS; k++) begin
         cand = PTR_W'((int'(last_grant) + k) % NUM_CHANNELS);
         if (!found && request[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

   assign oh_wide      = idx_to_onehot(32'(idx));
   assign unused_oh_hi = &{1'b0, oh_wide};

   assign grant_valid = found & enable;
   assign grant_idx   = idx;
   assign grant_oh    = grant_valid ? oh_wide[NUM_CHANNELS-1:0] : '0;

endmodule

// File: rtl/ah_arbitrated_multiplexor_8_8.sv
// Round-robin N:1 stream multiplexor with a single registered output stage
// and a one-hot source tag that a downstream demux can use as its select.
module ah_arbitrated_multiplexor_8_8
   import ah_mux_pkg::*;
#(
   parameter int DATA_WIDTH   = AH_DATA_WIDTH,
   parameter int NUM_CHANNELS = AH_NUM_CHANNELS
) (
   input logic    clk,
   input logic    reset,
   ah_mux_if.slave bus
);

   localparam int PTR_W = $clog2(NUM_CHANNELS);

   logic [PTR_W-1:0]        last_grant;
   logic                    load;
   logic [NUM_CHANNELS-1:0] grant_oh;
   logic [PTR_W-1:0]        grant_idx;
   logic                    grant_valid;
   logic [DATA_WIDTH-1:0]   sel_data;

   logic [DATA_WIDTH-1:0]   out_data_q;
   logic [NUM_CHANNELS-1:0] out_select_q;
   logic                    out_valid_q;

   assign load = !out_valid_q || bus.out_ready;

   // Reset masks the grant so no producer sees a handshake in the reset cycle.
   ah_round_robin_arbiter #(
      .NUM_CHANNELS (NUM_CHANNELS)
   ) u_arbiter (
      .request     (bus.in_valid),
      .last_grant  (last_grant),
      .enable      (load && !reset),
      .grant_oh    (grant_oh),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (grant_oh[i]) begin
            sel_data = sel_data | bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_select_q <= '0;
         last_grant   <= PTR_W'(NUM_CHANNELS - 1);
      end else if (load) begin
         if (grant_valid) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= sel_data;
            out_select_q <= grant_oh;
            last_grant   <= grant_idx;
         end else begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_select_q <= '0;
         end
      end
   end

   assign bus.in_ready   = grant_oh;
   assign bus.out_data   = out_data_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_select = out_select_q;

endmodule

// File: tb/tb_ah_arbitrated_multiplexor_8_8.sv
// Scenario bench for the round-robin multiplexor: a reference arbiter pushes
// expected {select, data} words as inputs are driven; outputs pop and compare.
module tb_ah_arbitrated_multiplexor_8_8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ah_mux_if #(.DATA_WIDTH(8), .NUM_CHANNELS(8)) bus ();

   ah_arbitrated_multiplexor_8_8 #(
      .DATA_WIDTH   (8),
      .NUM_CHANNELS (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] sb[$];
   logic [16:0] held;
   bit          m_valid;
   int          m_last;
   logic [7:0]  exp_ready;
   logic [7:0]  obs_ready;
   bit          xfer;

   task automatic set_counting_data();
      for (int i = 0; i < 8; i++) bus.in_data[i*8 +: 8] = 8'(8'h10 + i);
   endtask

   // Advance one clock: sample in_ready, predict the grant, push the expected
   // word on a transfer, and track the output register state.
   task automatic step();
      bit load;
      bit found;
      int g;
      int c;
      #1;
      obs_ready = bus.in_ready;
      xfer      = 1'b0;
      exp_ready = '0;
      load      = 1'b0;
      found     = 1'b0;
      g         = 0;
      if (!reset) begin
         load = !m_valid || bus.out_ready;
         for (int k = 1; k <= 8; k++) begin
            c = (m_last + k) % 8;
            if (!found && bus.in_valid[c]) begin
               found = 1'b1;
               g     = c;
            end
         end
         if (load && found) begin
            xfer      = 1'b1;
            exp_ready = 8'(1) << g;
            sb.push_back({exp_ready, bus.in_data[g*8 +: 8]});
         end
      end
      @(posedge clk);
      if (reset) begin
         m_valid = 1'b0;
         m_last  = 7;
         held    = '0;
         sb.delete();
      end else if (load) begin
         if (xfer) begin
            m_valid = 1'b1;
            m_last  = g;
         end else begin
            m_valid = 1'b0;
            held    = '0;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      bus.in_valid  = 8'hFF;
      bus.out_ready = 1'b1;
      set_counting_data();
      repeat (2) begin
         step();
         n_cmp++;
         if (obs_ready !== 8'h00) begin n_bad++; $display("FAIL reset_ready: got %h want 00", obs_ready); end
         n_cmp++;
         if ({bus.out_valid, bus.out_select, bus.out_data} !== 17'h0)
            begin n_bad++; $display("FAIL reset_out: got v=%b sel=%h d=%h want all zero", bus.out_valid, bus.out_select, bus.out_data); end
      end
      reset = 1'b0;
      step();
      if (xfer) held = {1'b1, sb.pop_front()};
      n_cmp++;
      if (obs_ready !== 8'h01) begin n_bad++; $display("FAIL first_grant_ready: got %h want 01", obs_ready); end
      n_cmp++;
      if (bus.out_select !== 8'h01 || bus.out_data !== 8'h10)
         begin n_bad++; $display("FAIL first_grant_out: got sel=%h d=%h want sel=01 d=10", bus.out_select, bus.out_data); end
   endtask

   task automatic test_single_channel();
      bus.in_valid          = 8'h08;
      bus.in_data[3*8 +: 8] = 8'hA5;
      bus.out_ready         = 1'b1;
      repeat (4) begin
         step();
         if (xfer) held = {1'b1, sb.pop_front()};
         n_cmp++;
         if (obs_ready !== exp_ready || obs_ready !== 8'h08)
            begin n_bad++; $display("FAIL single_ready: got %h want 08", obs_ready); end
         n_cmp++;
         if ({bus.out_valid, bus.out_select, bus.out_data} !== held || bus.out_data !== 8'hA5 || bus.out_select !== 8'h08)
            begin n_bad++; $display("FAIL single_out: got v=%b sel=%h d=%h want v=1 sel=08 d=a5", bus.out_valid, bus.out_select, bus.out_data); end
      end
      set_counting_data();
   endtask

   task automatic test_all_channels();
      reset = 1'b1;
      step();
      reset         = 1'b0;
      bus.in_valid  = 8'hFF;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         step();
         if (xfer) held = {1'b1, sb.pop_front()};
         n_cmp++;
         if (obs_ready !== exp_ready) begin n_bad++; $display("FAIL all_ready[%0d]: got %h want %h", k, obs_ready, exp_ready); end
         n_cmp++;
         if ({bus.out_valid, bus.out_select, bus.out_data} !== held ||
             bus.out_data !== 8'(8'h10 + k % 8) || bus.out_select !== 8'(8'h01 << (k % 8)))
            begin n_bad++; $display("FAIL all_out[%0d]: got sel=%h d=%h want sel=%h d=%h", k, bus.out_select, bus.out_data, 8'(8'h01 << (k % 8)), 8'(8'h10 + k % 8)); end
      end
   endtask

   task automatic test_backpressure();
      reset = 1'b1;
      step();
      reset         = 1'b0;
      bus.in_valid  = 8'hFF;
      bus.out_ready = 1'b1;
      step();
      if (xfer) held = {1'b1, sb.pop_front()};
      n_cmp++;
      if ({bus.out_valid, bus.out_select, bus.out_data} !== {1'b1, 8'h01, 8'h10})
         begin n_bad++; $display("FAIL bp_first: got sel=%h d=%h want sel=01 d=10", bus.out_select, bus.out_data); end
      bus.out_ready = 1'b0;
      repeat (3) begin
         step();
         if (xfer) held = {1'b1, sb.pop_front()};
         n_cmp++;
         if (obs_ready !== 8'h00 || exp_ready !== 8'h00) begin n_bad++; $display("FAIL bp_stall_ready: got %h want 00", obs_ready); end
         n_cmp++;
         if ({bus.out_valid, bus.out_select, bus.out_data} !== held || held !== {1'b1, 8'h01, 8'h10})
            begin n_bad++; $display("FAIL bp_stall_out: got v=%b sel=%h d=%h want v=1 sel=01 d=10", bus.out_valid, bus.out_select, bus.out_data); end
      end
      bus.out_ready = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         step();
         if (xfer) held = {1'b1, sb.pop_front()};
         n_cmp++;
         if (obs_ready !== 8'(8'h01 << k)) begin n_bad++; $display("FAIL bp_resume_ready[%0d]: got %h want %h", k, obs_ready, 8'(8'h01 << k)); end
         n_cmp++;
         if ({bus.out_valid, bus.out_select, bus.out_data} !== held || bus.out_data !== 8'(8'h10 + k))
            begin n_bad++; $display("FAIL bp_resume_out[%0d]: got sel=%h d=%h want d=%h", k, bus.out_select, bus.out_data, 8'(8'h10 + k)); end
      end
   endtask

   task automatic test_wrap_skip();
      logic [7:0] exp_sel[3];
      exp_sel = '{8'h01, 8'h40, 8'h01};
      reset = 1'b1;
      step();
      reset         = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 8'h40;
      step();
      if (xfer) held = {1'b1, sb.pop_front()};
      n_cmp++;
      if (bus.out_select !== 8'h40) begin n_bad++; $display("FAIL wrap_seed: got sel=%h want 40", bus.out_select); end
      bus.in_valid = 8'h41;
      for (int k = 0; k < 3; k++) begin
         step();
         if (xfer) held = {1'b1, sb.pop_front()};
         n_cmp++;
         if (obs_ready !== exp_ready || obs_ready !== exp_sel[k])
            begin n_bad++; $display("FAIL wrap_ready[%0d]: got %h want %h", k, obs_ready, exp_sel[k]); end
         n_cmp++;
         if ({bus.out_valid, bus.out_select, bus.out_data} !== held || bus.out_select !== exp_sel[k])
            begin n_bad++; $display("FAIL wrap_out[%0d]: got sel=%h d=%h want sel=%h", k, bus.out_select, bus.out_data, exp_sel[k]); end
      end
   endtask

   task automatic test_reset_mid_stall();
      bus.in_valid  = 8'hFF;
      bus.out_ready = 1'b1;
      step();
      if (xfer) held = {1'b1, sb.pop_front()};
      bus.out_ready = 1'b0;
      step();
      if (xfer) held = {1'b1, sb.pop_front()};
      n_cmp++;
      if ({bus.out_valid, bus.out_select, bus.out_data} !== held || bus.out_valid !== 1'b1)
         begin n_bad++; $display("FAIL rst_stall_hold: got v=%b sel=%h d=%h want v=1 held word", bus.out_valid, bus.out_select, bus.out_data); end
      reset = 1'b1;
      step();
      n_cmp++;
      if (obs_ready !== 8'h00) begin n_bad++; $display("FAIL rst_stall_ready: got %h want 00", obs_ready); end
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_select !== 8'h00 || bus.out_data !== 8'h00)
         begin n_bad++; $display("FAIL rst_stall_out: got v=%b sel=%h d=%h want zeros", bus.out_valid, bus.out_select, bus.out_data); end
      reset         = 1'b0;
      bus.out_ready = 1'b1;
      step();
      if (xfer) held = {1'b1, sb.pop_front()};
      n_cmp++;
      if ({bus.out_valid, bus.out_select, bus.out_data} !== held || bus.out_select !== 8'h01)
         begin n_bad++; $display("FAIL rst_stall_priority: got sel=%h want 01", bus.out_select); end
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      m_valid       = 1'b0;
      m_last        = 7;
      held          = '0;
      @(negedge clk);
      test_reset();
      test_single_channel();
      test_all_channels();
      test_backpressure();
      test_wrap_skip();
      test_reset_mid_stall();
      n_cmp++;
      if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ah_arbitrated_multiplexor_8_8.md
Name: ah_arbitrated_multiplexor_8_8

Overview:
- Inverse of the one-hot demultiplexor: gathers NUM_CHANNELS input streams onto a single output stream.
- Uses round-robin arbitration and valid/ready handshakes.
- Emits a one-hot out_select alongside each word. The downstream one-hot demux can consume it directly as its select to route responses back.
- Sits between per-channel producers and a shared datapath.
- Single registered output stage, 1-cycle latency.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- NUM_CHANNELS, 8, number of input channels (≥2).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  NUM_CHANNELS*DATA_WIDTH  packed channel words; channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  NUM_CHANNELS  per-channel valid.
- in_ready  output  NUM_CHANNELS  per-channel ready; at most one bit set.
- out_data  output  DATA_WIDTH  registered selected word.
- out_valid  output  1  out_data/out_select valid.
- out_ready  input  1  downstream accepts.
- out_select  output  NUM_CHANNELS  one-hot source channel of out_data; 0 when idle.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - out_valid=0, out_data=0, out_select=0.
  - Internal last_grant pointer = NUM_CHANNELS-1, so channel 0 has first priority.
- load = !out_valid | out_ready. This is the output register's capacity to take a word this cycle.
- Grant selection: combinational. The grant is the first channel with in_valid=1, searching from index last_grant+1 upward and wrapping modulo NUM_CHANNELS.
- in_ready:
  - in_ready[g]=1 only when load=1 and g is the granted channel; all other bits are 0.
  - in_ready may depend combinationally on in_valid and out_ready. Producers must not make in_valid depend on in_ready.
- Transfer on a channel occurs when in_valid[g] & in_ready[g]. On that edge:
  - out_data <= in_data[g];
  - out_select <= one-hot(g);
  - out_valid <= 1;
  - last_grant <= g.
- load=1 with no in_valid set: out_valid<=0, out_data<=0, out_select<=0; last_grant unchanged.
- Stall (out_valid=1, out_ready=0):
  - all in_ready=0;
  - out_data, out_select and out_valid hold stable;
  - last_grant unchanged;
  - an input's in_valid may remain asserted indefinitely.
- Throughput: one word per cycle when out_ready is held high and inputs are valid.
- Latency: one cycle from input transfer to out_valid.
- Fairness:
  - With all channels continuously valid, grants cycle 0,1,…,NUM_CHANNELS-1,0 in order.
  - No channel waits more than NUM_CHANNELS-1 grants.
- Wrap-around: with last_grant=NUM_CHANNELS-1, the search starts at channel 0.
- Single requester: it is granted every cycle that load=1, regardless of last_grant.
- Reset mid-operation: the held word is dropped with no transfer. In the reset cycle in_ready=0, and outputs take reset values on that edge.
- out_select is always one-hot while out_valid=1 and all-zero while out_valid=0.

Decomposition:
- Package ah_mux_pkg:
  - default DATA_WIDTH/NUM_CHANNELS constants;
  - function to convert an index to one-hot;
  - localparam for pointer width, $clog2(NUM_CHANNELS).
- Sub-module ah_round_robin_arbiter:
  - inputs: request vector, last_grant pointer, enable (load);
  - outputs: one-hot grant and encoded grant index; purely combinational.
- The top level holds the pointer register, output register and data mux.

Test Plan:
- Reset: assert reset 2 cycles with all in_valid=1 → in_ready=0, out_valid=0, out_data=0x00, out_select=0x00; first grant after reset is channel 0.
- Single channel: in_valid=0x08, in_data[3]=0xA5, out_ready=1 → in_ready=0x08; next cycle out_data=0xA5, out_select=0x08, out_valid=1; back-to-back every cycle.
- All channels: in_valid=0xFF, channel i data = 0x10+i, out_ready=1 → outputs 0x10,0x11,…,0x17,0x10 on consecutive cycles; out_select follows 0x01,0x02,…,0x80,0x01.
- Backpressure: drive all channels valid, drop out_ready for 3 cycles after the first output → out_data/out_select frozen, in_ready=0x00 for those cycles; on resume the next grant is the following channel with no word lost or duplicated.
- Wrap/skip: last grant = channel 6, in_valid=0x41 → grant channel 0, then channel 6, then channel 0.
- Reset mid-stall: out_valid=1, out_ready=0, assert reset → next cycle out_valid=0, out_select=0; after release channel 0 has priority.
